// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter for a single RAM port: instruction cache on side 0, data cache on side 1.
// Round-robin on ties, latched command, fixed RAM_LAT access window, one-cycle done pulse.
module ram_port_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int RAM_LAT = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ramAddr,
  output logic [DATA_W-1:0] ramDataOut,
  output logic              ramReadEnable,
  output logic              ramWriteEnable,
  input  logic [DATA_W-1:0] ramDataIn
);

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'b001,
    ACCESS = 3'b010,
    DONE   = 3'b100
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                owner_q, owner_d;
  logic                last_gnt_q, last_gnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                winner;

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    last_gnt_d = last_gnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    winner     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // A lone request wins outright; a tie goes to whoever was not served last.
          winner  = (req0 && req1) ? ~last_gnt_q : req1;
          owner_d = winner;
          we_d    = winner ? we1    : we0;
          addr_d  = winner ? addr1  : addr0;
          wdata_d = winner ? wdata1 : wdata0;
          cnt_d   = CNT_W'(RAM_LAT - 1);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          if (!we_q) rdata_d = ramDataIn;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        last_gnt_d = owner_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  // NOTE: the datapath registers are reset too, since ramAddr/ramDataOut/rdata must read 0 out of reset.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      owner_q    <= 1'b0;
      last_gnt_q <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      last_gnt_q <= last_gnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
    end
  end

  // Outputs decode straight from the state register, so an async reset drops them at once.
  logic in_access, owns_port, in_done;
  assign in_access = (state_q == ACCESS);
  assign in_done   = (state_q == DONE);
  assign owns_port = in_access || in_done;

  assign ramReadEnable  = in_access & ~we_q;
  assign ramWriteEnable = in_access &  we_q;
  assign ramAddr        = addr_q;
  assign ramDataOut     = wdata_q;
  assign gnt0           = owns_port & ~owner_q;
  assign gnt1           = owns_port &  owner_q;
  assign done0          = in_done & ~owner_q;
  assign done1          = in_done &  owner_q;
  assign rdata          = rdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: a RAM_LAT=2 instance for the main sequence
// and a RAM_LAT=1 instance for the short-latency read.
module tb_ram_port_arbiter;

  logic        clk;
  logic        clr;
  logic        req0, we0, req1, we1;
  logic [7:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1, ram_din;
  logic        gnt0, gnt1, done0, done1, rre, wre;
  logic [15:0] rdata, ram_dout;
  logic [7:0]  ram_addr;

  logic        b_req0, b_we0;
  logic [7:0]  b_addr0;
  logic [15:0] b_ram_din;
  logic        b_gnt0, b_gnt1, b_done0, b_done1, b_rre, b_wre;
  logic [15:0] b_rdata, b_ram_dout;
  logic [7:0]  b_ram_addr;

  int tests = 0;
  int fails = 0;

  ram_port_arbiter #(.ADDR_W(8), .DATA_W(16), .RAM_LAT(2)) dut (
    .clk(clk), .clr(clr),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata(rdata), .ramAddr(ram_addr), .ramDataOut(ram_dout),
    .ramReadEnable(rre), .ramWriteEnable(wre), .ramDataIn(ram_din)
  );

  ram_port_arbiter #(.ADDR_W(8), .DATA_W(16), .RAM_LAT(1)) dut_l1 (
    .clk(clk), .clr(clr),
    .req0(b_req0), .we0(b_we0), .addr0(b_addr0), .wdata0(16'h0000),
    .req1(1'b0), .we1(1'b0), .addr1(8'h00), .wdata1(16'h0000),
    .gnt0(b_gnt0), .gnt1(b_gnt1), .done0(b_done0), .done1(b_done1),
    .rdata(b_rdata), .ramAddr(b_ram_addr), .ramDataOut(b_ram_dout),
    .ramReadEnable(b_rre), .ramWriteEnable(b_wre), .ramDataIn(b_ram_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven and outputs sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr = 1'b1;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0; ram_din = '0;
    b_req0 = 0; b_we0 = 0; b_addr0 = '0; b_ram_din = '0;
    #2 clr = 1'b0;
    #10;
    check("rst_gnt", {gnt0, gnt1}, 2'b00);
    check("rst_done", {done0, done1}, 2'b00);
    check("rst_en", {rre, wre}, 2'b00);
    check("rst_rdata", rdata, 16'h0000);
    check("rst_addr", ram_addr, 8'h00);
    check("rst_dout", ram_dout, 16'h0000);
    clr = 1'b1;
    step();

    // 1: requester 0 read of 0x12
    req0 = 1; we0 = 0; addr0 = 8'h12; ram_din = 16'hBEEF;
    step();
    check("t1_rre_c1", rre, 1'b1);
    check("t1_addr_c1", ram_addr, 8'h12);
    check("t1_gnt0_c1", gnt0, 1'b1);
    check("t1_done0_c1", done0, 1'b0);
    step();
    check("t1_rre_c2", rre, 1'b1);
    check("t1_wre_c2", wre, 1'b0);
    step();
    check("t1_rre_done", rre, 1'b0);
    check("t1_done0", done0, 1'b1);
    check("t1_rdata", rdata, 16'hBEEF);
    check("t1_gnt0_done", gnt0, 1'b1);
    check("t1_side1", {gnt1, done1}, 2'b00);
    req0 = 0;
    step();
    check("t1_idle_done0", done0, 1'b0);
    check("t1_idle_gnt0", gnt0, 1'b0);

    // 2: requester 1 write; rdata must keep 0xBEEF
    req1 = 1; we1 = 1; addr1 = 8'h40; wdata1 = 16'h1234; ram_din = 16'h5555;
    step();
    check("t2_wre_c1", wre, 1'b1);
    check("t2_rre_c1", rre, 1'b0);
    check("t2_dout", ram_dout, 16'h1234);
    check("t2_addr", ram_addr, 8'h40);
    check("t2_gnt1", gnt1, 1'b1);
    step();
    check("t2_wre_c2", wre, 1'b1);
    step();
    check("t2_wre_done", wre, 1'b0);
    check("t2_done1", done1, 1'b1);
    check("t2_done0", done0, 1'b0);
    check("t2_rdata_hold", rdata, 16'hBEEF);
    req1 = 0;
    step();
    check("t2_idle_done1", done1, 1'b0);

    // 3: both requesting continuously from reset: grants alternate 0,1,0,1
    clr = 1'b0;
    #1;
    check("t3_rst_rdata", rdata, 16'h0000);
    req0 = 1; we0 = 0; addr0 = 8'h01;
    req1 = 1; we1 = 0; addr1 = 8'h02;
    #1 clr = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      logic exp_owner;
      exp_owner = (i % 2 == 1);
      check($sformatf("t3_gnt_%0d", i), {gnt1, gnt0}, exp_owner ? 2'b10 : 2'b01);
      check($sformatf("t3_addr_%0d", i), ram_addr, exp_owner ? 8'h02 : 8'h01);
      step();
      step();
      check($sformatf("t3_done_%0d", i), {done1, done0}, exp_owner ? 2'b10 : 2'b01);
      step();
      check($sformatf("t3_idle_%0d", i), {gnt1, gnt0, done1, done0}, 4'b0000);
      if (i == 3) begin
        req0 = 0;
        req1 = 0;
      end
      step();
    end
    check("t3_quiet", {gnt1, gnt0, rre, wre}, 4'b0000);

    // 4: inputs change during ACCESS; latched command must be used
    req0 = 1; we0 = 0; addr0 = 8'h33; ram_din = 16'hA5A5;
    step();
    check("t4_addr_c1", ram_addr, 8'h33);
    req0 = 0; addr0 = 8'h77;
    step();
    check("t4_addr_c2", ram_addr, 8'h33);
    check("t4_rre_c2", rre, 1'b1);
    step();
    check("t4_done0", done0, 1'b1);
    check("t4_rdata", rdata, 16'hA5A5);
    step();

    // 5: async reset in the second ACCESS cycle, then a tie goes to requester 0
    req0 = 1; we0 = 0; addr0 = 8'h55; ram_din = 16'h7777;
    step();
    req0 = 0;
    step();
    check("t5_rre_pre", rre, 1'b1);
    #2 clr = 1'b0;
    #1;
    check("t5_en_async", {rre, wre}, 2'b00);
    check("t5_gnt_async", {gnt0, gnt1}, 2'b00);
    check("t5_rdata_async", rdata, 16'h0000);
    step();
    check("t5_no_done", {done0, done1}, 2'b00);
    req0 = 1; req1 = 1; addr0 = 8'h66; addr1 = 8'h99; we1 = 0;
    clr = 1'b1;
    step();
    check("t5_tie_gnt", {gnt1, gnt0}, 2'b01);
    check("t5_tie_addr", ram_addr, 8'h66);
    req0 = 0; req1 = 0;
    step();
    step();
    check("t5_tie_done", {done1, done0}, 2'b01);
    step();

    // 6: RAM_LAT = 1 instance, read of 0xFF
    b_req0 = 1; b_we0 = 0; b_addr0 = 8'hFF; b_ram_din = 16'h0F0F;
    step();
    check("t6_rre_c1", b_rre, 1'b1);
    check("t6_addr", b_ram_addr, 8'hFF);
    check("t6_done_c1", b_done0, 1'b0);
    step();
    check("t6_rre_done", b_rre, 1'b0);
    check("t6_done0", b_done0, 1'b1);
    check("t6_rdata", b_rdata, 16'h0F0F);
    b_req0 = 0;
    step();
    check("t6_idle", {b_done0, b_gnt0, b_rre}, 3'b000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single RAM port between two cache controllers: requester 0 is the instruction-side cache, requester 1 is the data-side cache.
- Each requester issues one read or write over a req/done handshake.
- The arbiter picks one winner (round-robin on ties), latches its command, and drives the RAM enables for a fixed access latency.
- It then returns a one-cycle done pulse, plus read data for reads.

Parameters:
- ADDR_W, 8, RAM address width.
- DATA_W, 16, RAM data width.
- RAM_LAT, 2, cycles the RAM enables are held per access; legal range 1..15.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- clr  in  1  reset, asynchronous, active-low.
- req0  in  1  requester 0 access request.
- we0  in  1  requester 0 direction: 1 = write, 0 = read.
- addr0  in  ADDR_W  requester 0 address.
- wdata0  in  DATA_W  requester 0 write data.
- req1  in  1  requester 1 access request.
- we1  in  1  requester 1 direction: 1 = write, 0 = read.
- addr1  in  ADDR_W  requester 1 address.
- wdata1  in  DATA_W  requester 1 write data.
- gnt0  out  1  requester 0 owns the port (ACCESS and DONE states).
- gnt1  out  1  requester 1 owns the port (ACCESS and DONE states).
- done0  out  1  one-cycle completion pulse for requester 0.
- done1  out  1  one-cycle completion pulse for requester 1.
- rdata  out  DATA_W  read data; valid in the done cycle of a read.
- ramAddr  out  ADDR_W  RAM address.
- ramDataOut  out  DATA_W  RAM write data.
- ramReadEnable  out  1  RAM read strobe.
- ramWriteEnable  out  1  RAM write strobe.
- ramDataIn  in  DATA_W  RAM read data.

Behaviour:
- Reset (clr = 0, asynchronous):
  - state = IDLE, lastGnt = 1, so requester 0 wins the first tie.
  - cnt = 0.
  - All outputs = 0, including rdata, ramAddr and ramDataOut.
  - Reset mid-access aborts immediately: enables drop without waiting for clk, and no done pulse is issued.
- States (one-hot): IDLE, ACCESS, DONE.
- IDLE:
  - Only req0 = 1: winner 0.
  - Only req1 = 1: winner 1.
  - Both = 1: winner = ~lastGnt.
  - Neither: stay in IDLE.
  - On the winning edge, latch owner, we, addr and wdata of the winner into internal registers.
  - Load cnt = RAM_LAT - 1 and go to ACCESS.
- ACCESS:
  - Drive ramAddr and ramDataOut from the latched registers.
  - ramReadEnable = ~we_latched; ramWriteEnable = we_latched. The two are never both high.
  - gnt of the owner = 1.
  - cnt decrements each cycle. When cnt = 0, the next edge goes to DONE.
  - On that same edge, a read captures ramDataIn into rdata.
  - Enables are high for exactly RAM_LAT cycles.
- DONE:
  - Enables = 0.
  - done of the owner = 1 for one cycle; gnt stays high.
  - lastGnt <= owner; next state is IDLE.
- rdata holds its value across writes and idle cycles; it changes only on read completion.
- Latency: req sampled at edge k, ACCESS during cycles k+1..k+RAM_LAT, done during cycle k+RAM_LAT+1.
  - Back-to-back access: the next grant is at the earliest on the edge ending the IDLE cycle after DONE.
- Handshake rules:
  - The requester holds req, we, addr and wdata stable until done.
  - The requester deasserts req on the edge where done is sampled. Any req still high in IDLE is a new request.
  - Inputs are sampled only in IDLE. Changing or dropping req during ACCESS/DONE has no effect, and the access still completes with done.
- Fairness:
  - With both requesters continuously requesting, grants alternate 0, 1, 0, 1.
  - A lone requester may be granted repeatedly.
- RAM_LAT = 1: ACCESS lasts one cycle; cnt is loaded with 0.

Test Plan:
1. Reset, then req0 = 1, we0 = 0, addr0 = 0x12, RAM returns 0xBEEF; RAM_LAT = 2.
   -> ramReadEnable high for 2 cycles with ramAddr = 0x12.
   -> done0 pulses 3 cycles after the sampling edge; rdata = 0xBEEF; gnt1 and done1 stay 0.
2. req1 = 1, we1 = 1, addr1 = 0x40, wdata1 = 0x1234.
   -> ramWriteEnable high 2 cycles with ramDataOut = 0x1234; ramReadEnable stays 0.
   -> done1 pulses once; rdata unchanged from the prior value.
3. Both req0 and req1 high on the same edge, held continuously after reset.
   -> Grant order 0, 1, 0, 1; each done pulse is exactly 1 cycle; IDLE lasts 1 cycle between accesses.
4. req0 access in progress; drop req0 and toggle addr0 during ACCESS.
   -> ramAddr remains at the latched value; done0 still pulses.
5. Assert clr = 0 during the second ACCESS cycle.
   -> Enables, gnt and rdata go to 0 before the next clk edge; no done pulse.
   -> After clr = 1, a req0 + req1 tie grants 0 first.
6. RAM_LAT = 1 build, single read of addr 0xFF.
   -> ramReadEnable high for exactly 1 cycle; done0 2 cycles after the sampling edge.
